// File: rtl/core_run_controller.sv
// Run controller: holds the core in reset, runs it for a bounded cycle budget and reports
// pass/fail once core_out matches EXPECT_VALUE for STABLE_CYCLES consecutive RUN cycles.
// Optional macro CORE_RUN_TOGGLE_EN adds a saturating toggle_count output.
module core_run_controller #(
  parameter int                 OUT_W         = 4,
  parameter int                 HOLD_CYCLES   = 10,
  parameter int                 RUN_CYCLES    = 100,
  parameter logic [OUT_W-1:0]   EXPECT_VALUE  = 4'hA,
  parameter int                 STABLE_CYCLES = 4,
  parameter int                 CNT_W         = 16,
  parameter int                 AUTO_START    = 1
) (
  input  logic              clk_signal,
  input  logic              reset,
  input  logic              start,
  input  logic [OUT_W-1:0]  core_out,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [OUT_W-1:0]  last_out
`ifdef CORE_RUN_TOGGLE_EN
  ,
  output logic [CNT_W-1:0]  toggle_count
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HOLD = 3'd1,
    ST_RUN  = 3'd2,
    ST_PASS = 3'd3,
    ST_FAIL = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]   match_q, match_d;
  logic [CNT_W-1:0]   cycle_q, cycle_d;
  logic [OUT_W-1:0]   last_q, last_d;
  logic               auto_q, auto_d;
  logic               core_reset_q, busy_q, done_q, pass_q, fail_q;
`ifdef CORE_RUN_TOGGLE_EN
  logic [CNT_W-1:0]   toggle_q, toggle_d;
`endif

  // Next-state and counter update logic
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    match_d  = match_q;
    cycle_d  = cycle_q;
    last_d   = last_q;
    auto_d   = 1'b0;
`ifdef CORE_RUN_TOGGLE_EN
    toggle_d = toggle_q;
`endif
    case (state_q)
      ST_IDLE, ST_PASS, ST_FAIL: begin
        // auto_q is only set on the first edge after reset release
        if (start || ((state_q == ST_IDLE) && auto_q && (AUTO_START != 0))) begin
          state_d = ST_HOLD;
          hold_d  = CNT_W'(0);
          match_d = CNT_W'(0);
          cycle_d = CNT_W'(0);
          last_d  = OUT_W'(0);
`ifdef CORE_RUN_TOGGLE_EN
          toggle_d = CNT_W'(0);
`endif
        end else begin
          state_d = state_q;
        end
      end
      ST_HOLD: begin
        hold_d = hold_q + CNT_W'(1);
        if (hold_d == CNT_W'(HOLD_CYCLES)) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_RUN: begin
        cycle_d = cycle_q + CNT_W'(1);
        last_d  = core_out;
        if (core_out == EXPECT_VALUE) begin
          match_d = match_q + CNT_W'(1);
        end else begin
          match_d = CNT_W'(0);
        end
`ifdef CORE_RUN_TOGGLE_EN
        if ((core_out != last_q) && (toggle_q != {CNT_W{1'b1}})) begin
          toggle_d = toggle_q + CNT_W'(1);
        end else begin
          toggle_d = toggle_q;
        end
`endif
        // A stable match on the final budget edge still counts as a pass
        if (match_d == CNT_W'(STABLE_CYCLES)) begin
          state_d = ST_PASS;
        end else if (cycle_d == CNT_W'(RUN_CYCLES)) begin
          state_d = ST_FAIL;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs decoded from the next state
  always_ff @(posedge clk_signal or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      hold_q       <= CNT_W'(0);
      match_q      <= CNT_W'(0);
      cycle_q      <= CNT_W'(0);
      last_q       <= OUT_W'(0);
      auto_q       <= 1'b1;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
`ifdef CORE_RUN_TOGGLE_EN
      toggle_q     <= CNT_W'(0);
`endif
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      match_q      <= match_d;
      cycle_q      <= cycle_d;
      last_q       <= last_d;
      auto_q       <= auto_d;
      core_reset_q <= (state_d == ST_IDLE) || (state_d == ST_HOLD);
      busy_q       <= (state_d == ST_HOLD) || (state_d == ST_RUN);
      done_q       <= (state_d == ST_PASS) || (state_d == ST_FAIL);
      pass_q       <= (state_d == ST_PASS);
      fail_q       <= (state_d == ST_FAIL);
`ifdef CORE_RUN_TOGGLE_EN
      toggle_q     <= toggle_d;
`endif
    end
  end

  assign core_reset  = core_reset_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign cycle_count = cycle_q;
  assign last_out    = last_q;
`ifdef CORE_RUN_TOGGLE_EN
  assign toggle_count = toggle_q;
`endif

endmodule

// File: tb/tb_core_run_controller.sv
// Scoreboard bench for core_run_controller: stimulus pushes the reference outcome of each
// run, a monitor pops and compares it when done rises. Honours CORE_RUN_TOGGLE_EN.
module tb_core_run_controller;

  localparam int          OUT_W  = 4;
  localparam int          HOLD   = 10;
  localparam int          RUN    = 100;
  localparam int          STABLE = 4;
  localparam int          CNT_W  = 16;
  localparam logic [3:0]  EXP    = 4'hA;

  logic              clk_signal = 1'b0;
  logic              reset      = 1'b0;
  logic              start      = 1'b0;
  logic [OUT_W-1:0]  core_out   = 4'h0;
  logic              core_reset, busy, done, pass, fail;
  logic [CNT_W-1:0]  cycle_count;
  logic [OUT_W-1:0]  last_out;
`ifdef CORE_RUN_TOGGLE_EN
  logic [CNT_W-1:0]  toggle_count;
`endif

  always #5 clk_signal = ~clk_signal;

  core_run_controller #(
    .OUT_W(OUT_W), .HOLD_CYCLES(HOLD), .RUN_CYCLES(RUN), .EXPECT_VALUE(EXP),
    .STABLE_CYCLES(STABLE), .CNT_W(CNT_W), .AUTO_START(1)
  ) dut (
    .clk_signal (clk_signal),
    .reset      (reset),
    .start      (start),
    .core_out   (core_out),
    .core_reset (core_reset),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail       (fail),
    .cycle_count(cycle_count),
    .last_out   (last_out)
`ifdef CORE_RUN_TOGGLE_EN
    ,
    .toggle_count(toggle_count)
`endif
  );

  typedef struct packed {
    logic        p;
    logic [15:0] cc;
    logic [3:0]  lo;
    logic [15:0] tg;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [3:0]  pat [0:RUN];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Outcome from the rules: first RUN edge ending a window of STABLE matching samples, else budget end
  function automatic exp_t model();
    exp_t e;
    logic found;
    logic ok;
    e.p   = 1'b0;
    e.cc  = 16'(RUN);
    found = 1'b0;
    for (int n = STABLE; n <= RUN; n++) begin
      if (!found) begin
        ok = 1'b1;
        for (int k = n - STABLE + 1; k <= n; k++) begin
          if (pat[k] != EXP) ok = 1'b0;
        end
        if (ok) begin
          found = 1'b1;
          e.p   = 1'b1;
          e.cc  = 16'(n);
        end
      end
    end
    e.lo = pat[int'(e.cc)];
    e.tg = 16'h0;
    for (int k = 1; k <= RUN; k++) begin
      if ((k <= int'(e.cc)) && (pat[k] != pat[k-1]) && (e.tg != 16'hFFFF)) e.tg = e.tg + 16'd1;
    end
    return e;
  endfunction

  task automatic fill_const(input logic [3:0] v);
    for (int k = 0; k <= RUN; k++) pat[k] = v;
    pat[0] = 4'h0;
  endtask

  task automatic fill_random(input int pct_match);
    for (int k = 1; k <= RUN; k++) begin
      if ($urandom_range(0, 99) < pct_match) pat[k] = EXP;
      else pat[k] = 4'($urandom_range(0, 15));
    end
    pat[0] = 4'h0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_core_reset"}, 32'(core_reset), 32'(1'b1));
    chk({tag, "_busy"},       32'(busy),       32'(1'b0));
    chk({tag, "_done"},       32'(done),       32'(1'b0));
    chk({tag, "_pass"},       32'(pass),       32'(1'b0));
    chk({tag, "_fail"},       32'(fail),       32'(1'b0));
    chk({tag, "_cycle"},      32'(cycle_count), 32'(0));
    chk({tag, "_last"},       32'(last_out),   32'(0));
`ifdef CORE_RUN_TOGGLE_EN
    chk({tag, "_toggle"},     32'(toggle_count), 32'(0));
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk_signal);
    start = 1'b0;
    chk("restart_core_reset", 32'(core_reset), 32'(1'b1));
    chk("restart_busy",       32'(busy),       32'(1'b1));
    chk("restart_done",       32'(done),       32'(1'b0));
    chk("restart_pass",       32'(pass),       32'(1'b0));
    chk("restart_fail",       32'(fail),       32'(1'b0));
    chk("restart_cycle",      32'(cycle_count), 32'(0));
    chk("restart_last",       32'(last_out),   32'(0));
  endtask

  // mode: 0 plain, 1 start pulse before RUN edge 30, 2 reset at RUN edge 50, 3 start pulse in HOLD
  task automatic do_run(input int mode);
    int   n;
    int   w;
    logic got;
    if (mode != 2) sb.push_back(model());
    w = 0;
    while (core_reset && (w < 40)) begin
      @(negedge clk_signal);
      w++;
      if ((mode == 3) && (w == 3)) start = 1'b1;
      else start = 1'b0;
    end
    start = 1'b0;
    if (core_reset) begin
      chk("hold_release_timeout", 32'(core_reset), 32'(1'b0));
      return;
    end
    n        = 1;
    core_out = pat[1];
    got      = 1'b0;
    while (!got && (n <= RUN + 3)) begin
      @(negedge clk_signal);
      if (done) begin
        got = 1'b1;
      end else begin
        n++;
        core_out = (n <= RUN) ? pat[n] : 4'h0;
        if ((mode == 1) && (n == 30)) start = 1'b1;
        else start = 1'b0;
        if ((mode == 2) && (n == 50)) begin
          #1 reset = 1'b0;
          #1 check_idle_outputs("async_reset");
          repeat (3) @(negedge clk_signal);
          reset = 1'b1;
          return;
        end
      end
    end
    start = 1'b0;
    chk("run_terminated", 32'(done), 32'(1'b1));
  endtask

  // Monitor: measures HOLD length and compares each finished run against the scoreboard
  initial begin
    int   hold_cnt;
    logic prev_done;
    exp_t e;
    hold_cnt  = 0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk_signal);
      if (!reset) begin
        hold_cnt  = 0;
        prev_done = 1'b0;
      end else begin
        if (busy && core_reset) begin
          hold_cnt++;
        end else if (hold_cnt != 0) begin
          chk("hold_len", 32'(hold_cnt), 32'(HOLD));
          hold_cnt = 0;
        end
        if (done && !prev_done) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done actual=done required=no_done");
          end else begin
            e = sb.pop_front();
            chk("pass",        32'(pass),        32'(e.p));
            chk("fail",        32'(fail),        32'(!e.p));
            chk("cycle_count", 32'(cycle_count), 32'(e.cc));
            chk("last_out",    32'(last_out),    32'(e.lo));
            chk("done_busy",   32'(busy),        32'(1'b0));
            chk("done_corerst", 32'(core_reset), 32'(1'b0));
`ifdef CORE_RUN_TOGGLE_EN
            chk("toggle_count", 32'(toggle_count), 32'(e.tg));
`endif
          end
        end
        prev_done = done;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk_signal);
    check_idle_outputs("reset_state");
    reset = 1'b1;

    fill_const(4'h0);
    do_run(0);

    pulse_start();
    fill_const(4'h0);
    for (int k = 20; k <= RUN; k++) pat[k] = EXP;
    do_run(0);

    pulse_start();
    fill_const(4'h0);
    for (int k = 10; k <= RUN; k++) pat[k] = EXP;
    pat[13] = 4'h5;
    do_run(0);

    pulse_start();
    fill_const(4'h0);
    for (int k = 97; k <= RUN; k++) pat[k] = EXP;
    do_run(0);

    pulse_start();
    fill_const(4'h0);
    do_run(1);

    pulse_start();
    fill_const(4'h0);
    do_run(2);
    fill_random(60);
    do_run(0);

    pulse_start();
    fill_const(EXP);
    for (int k = 1; k <= 10; k++) pat[k] = 4'(k % 2 == 0 ? 1 : 0);
    do_run(3);

    for (int i = 0; i < 6; i++) begin
      pulse_start();
      fill_random((i % 2 == 0) ? 75 : 40);
      do_run(0);
    end

    repeat (2) @(negedge clk_signal);
    chk("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_run_controller.md
Name: core_run_controller

Overview:
- Synthesizable run controller that replaces hand-written reset/timeout sequencing for the pipelined core, both in simulation and on the FPGA board.
- Holds the core in reset for a programmable number of cycles, then releases it and runs it for a bounded cycle budget.
- Watches the core's output bus for an expected value that must stay stable, and reports pass or fail.
- Sits between board clock/reset and TOP; drives TOP's reset and observes its output bus (e.g. out_1).

Parameters:
- OUT_W, 4: width of the observed core output bus.
- HOLD_CYCLES, 10: cycles core_reset is held high before release; must be >= 1.
- RUN_CYCLES, 100: maximum RUN cycles before fail; must be < 2^CNT_W.
- EXPECT_VALUE, 4'hA: value (OUT_W bits) core_out must reach.
- STABLE_CYCLES, 4: consecutive matching RUN cycles required for pass; must be >= 1.
- CNT_W, 16: width of the cycle and hold counters.
- AUTO_START, 1: 1 = begin the HOLD sequence automatically after reset release; 0 = wait for start.

Ports:
- clk_signal  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset for this block.
- start  input  1  single-cycle request to (re)start the sequence.
- core_out  input  OUT_W  observed output bus of the core.
- core_reset  output  1  active-high reset driven to the core.
- busy  output  1  high in HOLD and RUN.
- done  output  1  high in PASS and FAIL.
- pass  output  1  high in PASS.
- fail  output  1  high in FAIL.
- cycle_count  output  CNT_W  number of RUN edges evaluated; frozen in PASS/FAIL.
- last_out  output  OUT_W  core_out captured at the most recent RUN edge.

Behaviour:
- Reset (reset=0), asynchronous: state=IDLE, core_reset=1, busy=0, done=0, pass=0, fail=0, cycle_count=0, last_out=0, hold counter=0, match counter=0. This takes effect immediately from any state, including mid-RUN.
- States: IDLE, HOLD, RUN, PASS, FAIL. Outputs are registered or decoded from the registered state, so there is no combinational path from core_out.
- IDLE: core_reset=1.
  - Go to HOLD on the next edge if AUTO_START=1 (first edge after reset release) or if start=1.
- HOLD: core_reset=1, busy=1.
  - The hold counter increments each edge.
  - After exactly HOLD_CYCLES edges in HOLD, go to RUN.
  - core_reset is therefore high for HOLD_CYCLES cycles after leaving IDLE.
- RUN: core_reset=0, busy=1. On each edge:
  - cycle_count increments and last_out <= core_out.
  - If core_out==EXPECT_VALUE, the match counter increments; otherwise it clears to 0.
  - If this edge makes the match counter equal STABLE_CYCLES, go to PASS.
  - Otherwise, if this edge makes cycle_count equal RUN_CYCLES, go to FAIL.
  - If both happen on the same edge, PASS wins.
- PASS / FAIL: core_reset=0 (core left running), busy=0, done=1, pass or fail=1 respectively. cycle_count and last_out hold.
- start=1 in PASS, FAIL or IDLE: go to HOLD on the next edge and clear cycle_count, counters, pass, fail and done. core_reset goes high that same edge.
- start is ignored in HOLD and RUN.
- Counters never wrap: parameter constraints guarantee that cycle_count stops at RUN_CYCLES.

Optional Feature:
- Macro CORE_RUN_TOGGLE_EN.
- Defined:
  - Adds output port toggle_count (CNT_W), reset to 0 and cleared on restart.
  - Increments on each RUN edge where core_out != last_out (the previous sample). The first RUN edge compares against the 0 left by reset/restart.
  - Saturates at all-ones; frozen in PASS/FAIL.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan (defaults unless stated):
- Release reset, core_out held 0 -> core_reset=1 for 10 cycles then 0; FAIL at RUN edge 100: fail=1, done=1, pass=0, cycle_count=100, last_out=0.
- core_out=4'hA from RUN edge 20 onward -> pass=1 after edge 23, cycle_count=23, last_out=4'hA, fail never set.
- core_out=4'hA on edges 10-12, 4'h5 on edge 13, 4'hA from edge 14 -> no pass at 13; pass at edge 17 with cycle_count=17.
- core_out=4'hA from edge 97 -> match completes on edge 100 -> pass=1, fail=0, cycle_count=100.
- Assert reset at RUN edge 50 -> all outputs return to reset values immediately (core_reset=1 without waiting for a clock); after release, HOLD of 10 cycles repeats.
- start pulse during RUN -> ignored. start pulse in FAIL -> flags clear, HOLD 10 cycles, new RUN from cycle_count=0.
- With CORE_RUN_TOGGLE_EN defined, core_out alternating 0/1 over 10 RUN edges -> toggle_count=9.
